// File: rtl/bsg_counter_up_down_sat.sv
// Up/down occupancy counter with multi-unit steps, saturate or modulo boundary,
// registered level flags and sticky overflow/underflow bits.
module bsg_counter_up_down_sat #(
    parameter int  max_val_p      = 9,
    parameter int  init_val_p     = 0,
    parameter int  max_step_p     = 1,
    parameter bit  saturate_p     = 1'b1,
    parameter int  almost_full_p  = max_val_p - 1,
    parameter int  almost_empty_p = 1,
    localparam int width_lp       = $clog2(max_val_p + 1),
    localparam int step_width_lp  = $clog2(max_step_p + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     clear_i,
    input  logic [step_width_lp-1:0] up_i,
    input  logic [step_width_lp-1:0] down_i,
    output logic [width_lp-1:0]      count_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic                     almost_full_o,
    output logic                     almost_empty_o,
    output logic                     overflow_o,
    output logic                     underflow_o
);

    // Two extra bits hold count+up (up to 2*max) and count-down (down to -max) exactly.
    localparam int sum_w_lp = width_lp + 2;
    typedef logic signed [sum_w_lp-1:0] sum_t;

    localparam sum_t                max_s_lp = sum_t'(max_val_p);
    localparam sum_t                mod_s_lp = sum_t'(max_val_p + 1);
    localparam logic [width_lp-1:0] init_lp  = width_lp'(init_val_p);

    logic [width_lp-1:0] count_q, count_d;
    logic                empty_q, empty_d;
    logic                full_q, full_d;
    logic                almost_full_q, almost_full_d;
    logic                almost_empty_q, almost_empty_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;

    sum_t sum;
    sum_t wrap_hi;
    sum_t wrap_lo;
    logic over;
    logic under;

    always_comb begin
        sum     = sum_t'(count_q) + sum_t'(up_i) - sum_t'(down_i);
        wrap_hi = sum - mod_s_lp;
        wrap_lo = sum + mod_s_lp;
        over    = (sum > max_s_lp);
        under   = sum[sum_w_lp-1];

        count_d     = width_lp'(sum);
        overflow_d  = overflow_q | over;
        underflow_d = underflow_q | under;

        if (clear_i) begin
            count_d     = init_lp;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else if (over) begin
            count_d = saturate_p ? width_lp'(max_s_lp) : width_lp'(wrap_hi);
        end else if (under) begin
            count_d = saturate_p ? '0 : width_lp'(wrap_lo);
        end

        // Flags follow the next count so they line up with count_o after the edge.
        empty_d        = (count_d == '0);
        full_d         = (int'(count_d) == max_val_p);
        almost_full_d  = (int'(count_d) >= almost_full_p);
        almost_empty_d = (int'(count_d) <= almost_empty_p);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q        <= init_lp;
            empty_q        <= (init_val_p == 0);
            full_q         <= (init_val_p == max_val_p);
            almost_full_q  <= (init_val_p >= almost_full_p);
            almost_empty_q <= (init_val_p <= almost_empty_p);
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            count_q        <= count_d;
            empty_q        <= empty_d;
            full_q         <= full_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    assign count_o        = count_q;
    assign empty_o        = empty_q;
    assign full_o         = full_q;
    assign almost_full_o  = almost_full_q;
    assign almost_empty_o = almost_empty_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_bsg_counter_up_down_sat.sv
// Scoreboard bench: three counter configurations (saturate, wrap, init=4) with
// directed vectors and a random soak against an integer model.
module tb_bsg_counter_up_down_sat;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       clr [3];
    logic [1:0] up  [3];
    logic [1:0] dn  [3];
    logic [3:0] cnt [3];
    logic       emp [3];
    logic       ful [3];
    logic       af  [3];
    logic       ae  [3];
    logic       ov  [3];
    logic       un  [3];

    bsg_counter_up_down_sat #(.max_val_p(9), .init_val_p(0), .max_step_p(3), .saturate_p(1'b1)) u_sat (
        .clk_i(clk), .reset_n_i(rst_n), .clear_i(clr[0]), .up_i(up[0]), .down_i(dn[0]),
        .count_o(cnt[0]), .empty_o(emp[0]), .full_o(ful[0]), .almost_full_o(af[0]),
        .almost_empty_o(ae[0]), .overflow_o(ov[0]), .underflow_o(un[0]));

    bsg_counter_up_down_sat #(.max_val_p(9), .init_val_p(0), .max_step_p(3), .saturate_p(1'b0)) u_wrap (
        .clk_i(clk), .reset_n_i(rst_n), .clear_i(clr[1]), .up_i(up[1]), .down_i(dn[1]),
        .count_o(cnt[1]), .empty_o(emp[1]), .full_o(ful[1]), .almost_full_o(af[1]),
        .almost_empty_o(ae[1]), .overflow_o(ov[1]), .underflow_o(un[1]));

    bsg_counter_up_down_sat #(.max_val_p(9), .init_val_p(4), .max_step_p(3), .saturate_p(1'b1)) u_init (
        .clk_i(clk), .reset_n_i(rst_n), .clear_i(clr[2]), .up_i(up[2]), .down_i(dn[2]),
        .count_o(cnt[2]), .empty_o(emp[2]), .full_o(ful[2]), .almost_full_o(af[2]),
        .almost_empty_o(ae[2]), .overflow_o(ov[2]), .underflow_o(un[2]));

    typedef struct {
        int         sel;
        int         due;
        logic [9:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++)
            assert (int'(up[k]) <= 3 && int'(dn[k]) <= 3) else $error("illegal step on dut%0d", k);
    end

    // Expected vector: count, empty, full, almost_full(>=8), almost_empty(<=1), overflow, underflow.
    function automatic logic [9:0] expv(input int c, input logic o, input logic u);
        expv = {4'(c), 1'(c == 0), 1'(c == 9), 1'(c >= 8), 1'(c <= 1), o, u};
    endfunction

    function automatic logic [9:0] actv(input int s);
        actv = {cnt[s], emp[s], ful[s], af[s], ae[s], ov[s], un[s]};
    endfunction

    task automatic check(input int s, input logic [9:0] e, input string name);
        logic [9:0] a;
        a = actv(s);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s dut%0d: got cnt=%0d flags(e,f,af,ae,ov,un)=%b, need cnt=%0d flags=%b",
                     name, s, a[9:6], a[5:0], e[9:6], e[5:0]);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            check(sb[0].sel, sb[0].exp, sb[0].name);
            void'(sb.pop_front());
        end
    end

    task automatic zero_inputs();
        for (int k = 0; k < 3; k++) begin
            clr[k] = 1'b0;
            up[k]  = 2'd0;
            dn[k]  = 2'd0;
        end
    endtask

    task automatic step(input int s, input logic c, input logic [1:0] u, input logic [1:0] d,
                        input int ec, input logic eo, input logic eu, input string name);
        @(posedge clk);
        #1;
        zero_inputs();
        clr[s] = c;
        up[s]  = u;
        dn[s]  = d;
        sb.push_back('{s, cyc + 1, expv(ec, eo, eu), name});
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        zero_inputs();
    endtask

    int         m   [2];
    logic       mo  [2];
    logic       mu  [2];
    int         sum;
    logic [1:0] su;
    logic [1:0] sd;
    logic       sc;
    string      nm;

    initial begin
        rst_n = 1'b1;
        zero_inputs();
        #1 rst_n = 1'b0;
        #2;
        check(0, expv(0, 0, 0), "rst_sat");
        check(1, expv(0, 0, 0), "rst_wrap");
        check(2, expv(4, 0, 0), "rst_init4");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        step(0, 0, 3, 0, 3, 0, 0, "up3_a");
        step(0, 0, 3, 0, 6, 0, 0, "up3_b");
        step(0, 0, 3, 0, 9, 0, 0, "up3_full");
        idle();
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check(0, expv(0, 0, 0), "async_rst_mid");
        @(negedge clk);
        rst_n = 1'b1;

        step(0, 0, 3, 0, 3, 0, 0, "sat_a");
        step(0, 0, 3, 0, 6, 0, 0, "sat_b");
        step(0, 0, 2, 0, 8, 0, 0, "sat_c");
        step(0, 0, 3, 0, 9, 1, 0, "sat_ovf");
        step(0, 0, 0, 1, 8, 1, 0, "sat_ovf_sticky");
        step(0, 1, 0, 0, 0, 0, 0, "clr_sat");
        step(0, 0, 3, 0, 3, 0, 0, "sim_a");
        step(0, 0, 2, 0, 5, 0, 0, "sim_b");
        step(0, 0, 2, 2, 5, 0, 0, "sim_equal");
        step(0, 0, 1, 3, 3, 0, 0, "sim_net");
        step(0, 0, 0, 3, 0, 0, 0, "dn_to_zero");
        step(0, 0, 0, 1, 0, 0, 1, "sat_unf");

        step(1, 0, 3, 0, 3, 0, 0, "wrap_a");
        step(1, 0, 3, 0, 6, 0, 0, "wrap_b");
        step(1, 0, 2, 0, 8, 0, 0, "wrap_c");
        step(1, 0, 3, 0, 1, 1, 0, "wrap_ovf");
        step(1, 0, 0, 3, 8, 1, 1, "wrap_unf");

        step(2, 0, 3, 0, 7, 0, 0, "i4_a");
        step(2, 0, 3, 0, 9, 1, 0, "i4_ovf");
        step(2, 0, 0, 3, 6, 1, 0, "i4_b");
        step(2, 0, 0, 3, 3, 1, 0, "i4_c");
        step(2, 0, 0, 3, 0, 1, 0, "i4_d");
        step(2, 0, 0, 1, 0, 1, 1, "i4_unf");
        step(2, 0, 3, 0, 3, 1, 1, "i4_e");
        step(2, 0, 3, 0, 6, 1, 1, "i4_f");
        step(2, 0, 1, 0, 7, 1, 1, "i4_at7");
        step(2, 1, 3, 0, 4, 0, 0, "clr_priority");
        step(2, 0, 1, 0, 5, 0, 0, "after_clr");
        idle();

        for (int i = 0; i < 10000; i++) begin
            @(posedge clk);
            #1;
            for (int s = 0; s < 2; s++) begin
                sc = (i == 0) || ($urandom_range(63) == 0);
                su = 2'($urandom_range(3));
                sd = 2'($urandom_range(3));
                clr[s] = sc;
                up[s]  = su;
                dn[s]  = sd;
                if (sc) begin
                    m[s]  = 0;
                    mo[s] = 1'b0;
                    mu[s] = 1'b0;
                end else begin
                    sum = m[s] + int'(su) - int'(sd);
                    if (sum > 9) begin
                        mo[s] = 1'b1;
                        m[s]  = (s == 0) ? 9 : sum - 10;
                    end else if (sum < 0) begin
                        mu[s] = 1'b1;
                        m[s]  = (s == 0) ? 0 : sum + 10;
                    end else begin
                        m[s] = sum;
                    end
                end
                if (s == 0) nm = "soak_sat";
                else        nm = "soak_wrap";
                sb.push_back('{s, cyc + 1, expv(m[s], mo[s], mu[s]), nm});
            end
        end
        idle();

        for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left unchecked, need 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsg_counter_up_down_sat.md
# bsg_counter_up_down_sat

Parametrised up/down occupancy counter for credit and occupancy tracking in `bp_quad` flow-control paths. It adds a multi-unit step per cycle, a selectable saturate or modulo boundary mode, registered threshold flags, and sticky overflow/underflow error bits. It replaces fixed-step counters in channels that accept or release several credits per cycle.

## Interface
Parameters:
- `max_val_p`, 9: largest representable count; must be ≥ 1.
- `init_val_p`, 0: count value after reset or clear; must be ≤ `max_val_p`.
- `max_step_p`, 1: largest `up_i` or `down_i` value in one cycle; must be ≥ 1 and ≤ `max_val_p`.
- `saturate_p`, 1: 1 clamps the count to [0, `max_val_p`]; 0 wraps modulo (`max_val_p`+1).
- `almost_full_p`, `max_val_p`-1: `almost_full_o` asserts when count ≥ this value.
- `almost_empty_p`, 1: `almost_empty_o` asserts when count ≤ this value.
- Derived `width_lp` = clog2(`max_val_p`+1); `step_width_lp` = clog2(`max_step_p`+1).

Ports:
- `clk_i`, in, 1: clock; all state updates on the rising edge.
- `reset_n_i`, in, 1: reset, asynchronous, active-low.
- `clear_i`, in, 1: synchronous return to `init_val_p`; also clears the error bits.
- `up_i`, in, `step_width_lp`: increment amount this cycle.
- `down_i`, in, `step_width_lp`: decrement amount this cycle.
- `count_o`, out, `width_lp`: current count, registered.
- `empty_o`, out, 1: count == 0.
- `full_o`, out, 1: count == `max_val_p`.
- `almost_full_o`, out, 1: count ≥ `almost_full_p`.
- `almost_empty_o`, out, 1: count ≤ `almost_empty_p`.
- `overflow_o`, out, 1: sticky; set when an update exceeds `max_val_p`.
- `underflow_o`, out, 1: sticky; set when an update goes below 0.

## Operation
- Each cycle, compute `sum = count_o + up_i - down_i` in signed arithmetic at width `width_lp`+2. No intermediate truncation is allowed.
- Simultaneous `up_i` and `down_i` apply their net difference. Equal values leave the count unchanged and set no error.
- Inputs above `max_step_p` are illegal. The block does not check them. The bench asserts they never occur.
- Case `sum` > `max_val_p`:
  - `saturate_p`=1: next count = `max_val_p`.
  - `saturate_p`=0: next count = `sum` - (`max_val_p`+1).
  - `overflow_o` is set in both modes.
- Case `sum` < 0:
  - `saturate_p`=1: next count = 0.
  - `saturate_p`=0: next count = `sum` + (`max_val_p`+1).
  - `underflow_o` is set in both modes.
- Otherwise, next count = `sum`.
- `clear_i` takes priority over `up_i` and `down_i`. On clear: count = `init_val_p`, and `overflow_o` = `underflow_o` = 0. The step inputs are ignored that cycle.
- Error bits stay set until reset or `clear_i`.
- All four level flags are registered. They are computed from the next count, so they always agree with `count_o` in the same cycle.

## Timing
- Reset (`reset_n_i`=0, asynchronous, at any time, including mid-update):
  - `count_o` = `init_val_p`.
  - `empty_o`, `full_o`, `almost_full_o`, `almost_empty_o` take their values for `init_val_p`.
  - `overflow_o` = `underflow_o` = 0.
- Deassertion of reset is taken synchronously. The first update happens on the first rising edge with `reset_n_i`=1.
- Latency: an input applied in cycle N is reflected in `count_o`, the level flags and the error bits after edge N+1.
- The block has no combinational path from any input to any output.
- Throughput: one update per cycle, with no stall or backpressure.

## Test plan
Defaults unless stated: `max_val_p`=9, `init_val_p`=0, `max_step_p`=3.
- Reset and step up:
  - Assert `reset_n_i`=0 mid-cycle → count 0, `empty_o`=1, `almost_empty_o`=1, errors 0, with no clock edge needed.
  - Release reset, apply `up_i`=3 for 3 cycles → count 3, 6, 9; `full_o`=1 and `almost_full_o`=1 in the same cycle as 9.
- Saturate overflow (`saturate_p`=1): from 8, `up_i`=3 → count 9, `overflow_o`=1; then `down_i`=1 → count 8, `overflow_o` stays 1.
- Wrap mode (`saturate_p`=0):
  - From 8, `up_i`=3 → count 1, `overflow_o`=1.
  - From 1, `down_i`=3 → count 8, `underflow_o`=1.
- Simultaneous steps: from 5, `up_i`=2 with `down_i`=2 → count 5, no error; then `up_i`=1 with `down_i`=3 → count 3.
- Clear priority:
  - `init_val_p`=4, errors set, count 7.
  - Apply `clear_i`=1 with `up_i`=3 → count 4, both errors 0.
  - Next cycle, `up_i`=1 → count 5.
- Random soak (`saturate_p` 0 and 1): 10k cycles of random legal steps against a reference model → `count_o`, all flags and error bits match every cycle.
